// File: rtl/fetch_stage.sv
// F stage of the five-stage MIPS pipeline: PC register, next-PC selection,
// fetch address-error detection and the F/D pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] TEXT_LO   = 32'h0000_3000,
  parameter logic [31:0] TEXT_HI   = 32'h0000_6ffc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        req,
  input  logic [31:0] EPC,
  input  logic        D_eret,
  input  logic        D_BJ,
  input  logic        npc_sel,
  input  logic [31:0] npc_target,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] F_PC,
  output logic [31:0] D_Instr,
  output logic [31:0] D_PC,
  output logic [4:0]  D_ExcCode,
  output logic        D_BD
);

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  logic        f_adel;
  logic [31:0] f_instr;
  logic [4:0]  f_exc_code;
  logic [31:0] pc_plus4;

  // A faulting fetch enters D as a nop that carries the AdEL code and its PC.
  assign f_adel     = (F_PC[1:0] != 2'b00) || (F_PC < TEXT_LO) || (F_PC > TEXT_HI);
  assign f_instr    = f_adel ? 32'd0 : i_inst_rdata;
  assign f_exc_code = f_adel ? EXC_ADEL : EXC_NONE;
  assign pc_plus4   = F_PC + 32'd4;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      F_PC      <= RESET_PC;
      D_Instr   <= 32'd0;
      D_PC      <= 32'd0;
      D_ExcCode <= EXC_NONE;
      D_BD      <= 1'b0;
    end else if (req) begin
      F_PC      <= EXC_ENTRY;
      D_Instr   <= 32'd0;
      D_PC      <= EXC_ENTRY;
      D_ExcCode <= EXC_NONE;
      D_BD      <= 1'b0;
    end else if (!stall) begin
      if (D_eret) begin
        // eret has no delay slot, so the wrong-path fetch becomes a bubble
        F_PC      <= EPC;
        D_Instr   <= 32'd0;
        D_PC      <= EPC;
        D_ExcCode <= EXC_NONE;
        D_BD      <= 1'b0;
      end else begin
        F_PC      <= npc_sel ? npc_target : pc_plus4;
        D_Instr   <= f_instr;
        D_PC      <= F_PC;
        D_ExcCode <= f_exc_code;
        D_BD      <= D_BJ;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage: reset, sequential fetch,
// stalls, delay slots, address errors, exceptions, eret and wrap-around.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        req;
  logic [31:0] EPC;
  logic        D_eret;
  logic        D_BJ;
  logic        npc_sel;
  logic [31:0] npc_target;
  logic [31:0] i_inst_rdata;
  logic [31:0] F_PC;
  logic [31:0] D_Instr;
  logic [31:0] D_PC;
  logic [4:0]  D_ExcCode;
  logic        D_BD;

  int pass_count  = 0;
  int total_count = 0;

  fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .req          (req),
    .EPC          (EPC),
    .D_eret       (D_eret),
    .D_BJ         (D_BJ),
    .npc_sel      (npc_sel),
    .npc_target   (npc_target),
    .i_inst_rdata (i_inst_rdata),
    .F_PC         (F_PC),
    .D_Instr      (D_Instr),
    .D_PC         (D_PC),
    .D_ExcCode    (D_ExcCode),
    .D_BD         (D_BD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total_count++;
    assert (observed === expected) pass_count++;
    else begin
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      $error("[TB] %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic r, input logic er,
                               input logic bj, input logic sel,
                               input logic [31:0] tgt, input logic [31:0] rd);
    stall        = s;
    req          = r;
    D_eret       = er;
    D_BJ         = bj;
    npc_sel      = sel;
    npc_target   = tgt;
    i_inst_rdata = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkD(input string tag, input logic [31:0] instr,
                        input logic [31:0] pc, input logic [4:0] exc,
                        input logic bd);
    checkOutput({tag, ".instr"}, D_Instr, instr);
    checkOutput({tag, ".pc"}, D_PC, pc);
    checkOutput({tag, ".exc"}, {27'd0, D_ExcCode}, {27'd0, exc});
    checkOutput({tag, ".bd"}, {31'd0, D_BD}, {31'd0, bd});
  endtask

  initial begin
    reset = 1'b0;
    EPC   = 32'd0;
    applyStimulus(0, 0, 0, 0, 0, 32'd0, 32'h3c01_1234);

    // Reset held low for three edges
    repeat (3) tick();
    checkOutput("reset.fpc", F_PC, 32'h0000_3000);
    checkD("reset", 32'd0, 32'd0, 5'd0, 1'b0);

    reset = 1'b1;
    tick();
    checkOutput("first.fpc", F_PC, 32'h0000_3004);
    checkD("first", 32'h3c01_1234, 32'h0000_3000, 5'd0, 1'b0);

    applyStimulus(0, 0, 0, 0, 0, 32'd0, 32'h2001_0005);
    tick();
    checkOutput("seq.fpc", F_PC, 32'h0000_3008);
    checkD("seq", 32'h2001_0005, 32'h0000_3004, 5'd0, 1'b0);

    // Stall for two edges: nothing moves
    applyStimulus(1, 0, 0, 0, 0, 32'd0, 32'hdead_beef);
    tick();
    checkOutput("stall1.fpc", F_PC, 32'h0000_3008);
    checkD("stall1", 32'h2001_0005, 32'h0000_3004, 5'd0, 1'b0);
    tick();
    checkOutput("stall2.fpc", F_PC, 32'h0000_3008);
    checkD("stall2", 32'h2001_0005, 32'h0000_3004, 5'd0, 1'b0);

    applyStimulus(0, 0, 0, 0, 0, 32'd0, 32'h0000_0001);
    tick();
    checkOutput("unstall.fpc", F_PC, 32'h0000_300c);
    checkD("unstall", 32'h0000_0001, 32'h0000_3008, 5'd0, 1'b0);

    tick();
    checkOutput("pre_bj.fpc", F_PC, 32'h0000_3010);

    // Taken branch in D: the fetched instruction is its delay slot
    applyStimulus(0, 0, 0, 1, 1, 32'h0000_3100, 32'h1000_0003);
    tick();
    checkOutput("bj.fpc", F_PC, 32'h0000_3100);
    checkD("bj", 32'h1000_0003, 32'h0000_3010, 5'd0, 1'b1);

    applyStimulus(0, 0, 0, 0, 0, 32'd0, 32'h0000_0002);
    tick();
    checkOutput("post_bj.fpc", F_PC, 32'h0000_3104);
    checkD("post_bj", 32'h0000_0002, 32'h0000_3100, 5'd0, 1'b0);

    // D_BJ under stall must not set the delay-slot flag
    applyStimulus(1, 0, 0, 1, 0, 32'd0, 32'h0000_0003);
    tick();
    checkOutput("bj_stall.fpc", F_PC, 32'h0000_3104);
    checkD("bj_stall", 32'h0000_0002, 32'h0000_3100, 5'd0, 1'b0);

    // Misaligned jump target
    applyStimulus(0, 0, 0, 0, 1, 32'h0000_3102, 32'h0000_0004);
    tick();
    checkOutput("mis_jmp.fpc", F_PC, 32'h0000_3102);
    checkD("mis_jmp", 32'h0000_0004, 32'h0000_3104, 5'd0, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 32'd0, 32'h1111_1111);
    tick();
    checkOutput("mis_d.fpc", F_PC, 32'h0000_3106);
    checkD("mis_d", 32'd0, 32'h0000_3102, 5'd4, 1'b0);

    // Out-of-range target just above TEXT_HI
    applyStimulus(0, 0, 0, 0, 1, 32'h0000_7000, 32'h2222_2222);
    tick();
    checkOutput("hi_jmp.fpc", F_PC, 32'h0000_7000);
    applyStimulus(0, 0, 0, 0, 0, 32'd0, 32'h3333_3333);
    tick();
    checkOutput("hi_d.fpc", F_PC, 32'h0000_7004);
    checkD("hi_d", 32'd0, 32'h0000_7000, 5'd4, 1'b0);

    // TEXT_HI itself is legal
    applyStimulus(0, 0, 0, 0, 1, 32'h0000_6ffc, 32'h4444_4444);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 32'd0, 32'h5555_5555);
    tick();
    checkOutput("edge_hi.fpc", F_PC, 32'h0000_7000);
    checkD("edge_hi", 32'h5555_5555, 32'h0000_6ffc, 5'd0, 1'b0);

    // Just below TEXT_LO faults
    applyStimulus(0, 0, 0, 0, 1, 32'h0000_2ffc, 32'h6666_6666);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 32'h0000_3020, 32'h7777_7777);
    tick();
    checkOutput("lo.fpc", F_PC, 32'h0000_3020);
    checkD("lo", 32'd0, 32'h0000_2ffc, 5'd4, 1'b0);

    // Exception request overrides stall
    applyStimulus(1, 1, 0, 1, 0, 32'd0, 32'h8888_8888);
    tick();
    checkOutput("req.fpc", F_PC, 32'h0000_4180);
    checkD("req", 32'd0, 32'h0000_4180, 5'd0, 1'b0);

    applyStimulus(0, 0, 0, 0, 0, 32'd0, 32'h9999_9999);
    tick();
    checkOutput("handler.fpc", F_PC, 32'h0000_4184);
    checkD("handler", 32'h9999_9999, 32'h0000_4180, 5'd0, 1'b0);

    // eret redirects to EPC and squashes the fetch
    EPC = 32'h0000_3040;
    applyStimulus(0, 0, 1, 0, 0, 32'd0, 32'haaaa_aaaa);
    tick();
    checkOutput("eret.fpc", F_PC, 32'h0000_3040);
    checkD("eret", 32'd0, 32'h0000_3040, 5'd0, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 32'd0, 32'hbbbb_bbbb);
    tick();
    checkOutput("post_eret.fpc", F_PC, 32'h0000_3044);
    checkD("post_eret", 32'hbbbb_bbbb, 32'h0000_3040, 5'd0, 1'b0);

    // eret held under stall waits for the stall to drop
    EPC = 32'h0000_3080;
    applyStimulus(1, 0, 1, 0, 0, 32'd0, 32'hcccc_cccc);
    tick();
    checkOutput("eret_st1.fpc", F_PC, 32'h0000_3044);
    checkD("eret_st1", 32'hbbbb_bbbb, 32'h0000_3040, 5'd0, 1'b0);
    tick();
    checkOutput("eret_st2.fpc", F_PC, 32'h0000_3044);
    applyStimulus(0, 0, 1, 0, 0, 32'd0, 32'hcccc_cccc);
    tick();
    checkOutput("eret_go.fpc", F_PC, 32'h0000_3080);
    checkD("eret_go", 32'd0, 32'h0000_3080, 5'd0, 1'b0);

    // PC+4 wraps at the top of the address space
    applyStimulus(0, 0, 0, 0, 1, 32'hffff_fffc, 32'hdddd_dddd);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 32'd0, 32'heeee_eeee);
    tick();
    checkOutput("wrap.fpc", F_PC, 32'h0000_0000);
    checkD("wrap", 32'd0, 32'hffff_fffc, 5'd4, 1'b0);

    // Asynchronous reset mid-operation
    tick();
    reset = 1'b0;
    #2;
    checkOutput("async.fpc", F_PC, 32'h0000_3000);
    checkD("async", 32'd0, 32'd0, 5'd0, 1'b0);
    tick();
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 32'd0, 32'h0123_4567);
    tick();
    checkOutput("rerun.fpc", F_PC, 32'h0000_3004);
    checkD("rerun", 32'h0123_4567, 32'h0000_3000, 5'd0, 1'b0);

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
